// File: rtl/maze_pkg.sv
// Shared types and widths for the maze player sequencer.
package maze_pkg;

    localparam int BLOCK_W     = 6;
    localparam int MAZE_ADDR_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        READ,
        CHECK,
        WIN
    } ctrl_state_t;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

endpackage

// File: rtl/btn_dir_sel.sv
// Direction button edge detector, priority selector and hold-to-repeat timer.
module btn_dir_sel
    import maze_pkg::*;
#(
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic up,
    input  logic down,
    input  logic left,
    input  logic right,
    output logic req,
    output dir_t dir
);

    localparam int CW = $clog2(REPEAT_CYCLES);

    logic [3:0]    held, prev, rise, sel;
    logic [CW-1:0] cnt;
    logic          rpt;

    assign held = {up, down, left, right};
    assign rise = held & ~prev;
    // Repeat fires only while one unchanged direction stays held for a full interval.
    assign rpt  = $onehot(held) && (held == prev) && (cnt == CW'(REPEAT_CYCLES - 1));

    always_comb begin
        dir = DIR_NONE;
        sel = (|rise) ? rise : (rpt ? held : 4'b0000);
        if (sel[3])      dir = DIR_UP;
        else if (sel[2]) dir = DIR_DOWN;
        else if (sel[1]) dir = DIR_LEFT;
        else if (sel[0]) dir = DIR_RIGHT;
        req = |sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= '0;
            cnt  <= '0;
        end else begin
            prev <= held;
            if (!$onehot(held) || (held != prev) || rpt)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/maze_player_ctrl.sv
// Maze game sequencer: direction request -> bounds check -> ROM wall check -> player move.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int          MAZE_COLS     = 40,
    parameter int          MAZE_ROWS     = 30,
    parameter int          START_BCOL    = 1,
    parameter int          START_BROW    = 1,
    parameter int          EXIT_BCOL     = 38,
    parameter int          EXIT_BROW     = 28,
    parameter logic [11:0] WALL_RGB      = 12'h000,
    parameter int          REPEAT_CYCLES = 5000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_up,
    input  logic                   i_down,
    input  logic                   i_left,
    input  logic                   i_right,
    input  logic                   i_restart,
    output logic                   o_rom_en,
    output logic [MAZE_ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]            i_rom_dout,
    output logic [BLOCK_W-1:0]     o_player_bcol,
    output logic [BLOCK_W-1:0]     o_player_brow,
    output logic [BLOCK_W-1:0]     o_exit_bcol,
    output logic [BLOCK_W-1:0]     o_exit_brow,
    output logic                   o_win,
    output logic [15:0]            o_move_cnt
);

    localparam logic [BLOCK_W:0] ONE = 1;

    ctrl_state_t          state, state_nxt;
    logic                 req;
    dir_t                 dir;
    // Targets carry one extra bit so 0-1 underflow lands out of range.
    logic [BLOCK_W:0]     tcol, trow, tcol_nxt, trow_nxt;
    logic [BLOCK_W-1:0]   pcol, prow;
    logic [11:0]          color;
    logic [15:0]          move_cnt;
    logic                 win, in_bounds, wall_hit, at_exit;
    logic                 unused_dout;

    btn_dir_sel #(.REPEAT_CYCLES(REPEAT_CYCLES)) u_sel (
        .clk   (clk),
        .rst   (rst),
        .up    (i_up),
        .down  (i_down),
        .left  (i_left),
        .right (i_right),
        .req   (req),
        .dir   (dir)
    );

    assign in_bounds   = (tcol < (BLOCK_W+1)'(MAZE_COLS)) && (trow < (BLOCK_W+1)'(MAZE_ROWS));
    assign wall_hit    = (color == WALL_RGB);
    assign at_exit     = (tcol == (BLOCK_W+1)'(EXIT_BCOL)) && (trow == (BLOCK_W+1)'(EXIT_BROW));
    assign unused_dout = ^i_rom_dout[3:0];

    always_comb begin
        tcol_nxt = {1'b0, pcol};
        trow_nxt = {1'b0, prow};
        case (dir)
            DIR_UP:    trow_nxt = {1'b0, prow} - ONE;
            DIR_DOWN:  trow_nxt = {1'b0, prow} + ONE;
            DIR_LEFT:  tcol_nxt = {1'b0, pcol} - ONE;
            DIR_RIGHT: tcol_nxt = {1'b0, pcol} + ONE;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = CALC;
            CALC:    state_nxt = in_bounds ? READ : IDLE;
            READ:    state_nxt = CHECK;
            CHECK:   state_nxt = (!wall_hit && at_exit) ? WIN : IDLE;
            WIN:     state_nxt = WIN;
            default: state_nxt = IDLE;
        endcase
        if (i_restart) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcol     <= '0;
            trow     <= '0;
            color    <= '0;
            pcol     <= BLOCK_W'(START_BCOL);
            prow     <= BLOCK_W'(START_BROW);
            move_cnt <= '0;
            win      <= 1'b0;
        end else if (i_restart) begin
            pcol     <= BLOCK_W'(START_BCOL);
            prow     <= BLOCK_W'(START_BROW);
            move_cnt <= '0;
            win      <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                tcol <= tcol_nxt;
                trow <= trow_nxt;
            end
            if (state == READ)
                color <= i_rom_dout[15:4];
            if (state == CHECK && !wall_hit) begin
                pcol <= tcol[BLOCK_W-1:0];
                prow <= trow[BLOCK_W-1:0];
                if (move_cnt != 16'hFFFF) move_cnt <= move_cnt + 16'd1;
                if (at_exit) win <= 1'b1;
            end
        end
    end

    assign o_rom_en      = (state == CALC) && in_bounds;
    assign o_rom_addr    = {trow[BLOCK_W-1:0], tcol[BLOCK_W-1:0]};
    assign o_player_bcol = pcol;
    assign o_player_brow = prow;
    assign o_exit_bcol   = BLOCK_W'(EXIT_BCOL);
    assign o_exit_brow   = BLOCK_W'(EXIT_BROW);
    assign o_win         = win;
    assign o_move_cnt    = move_cnt;

endmodule

// File: tb/tb_maze_player_ctrl.sv
// Directed + randomized bench for maze_player_ctrl against a grid-level reference model.
module tb_maze_player_ctrl;

    localparam int COLS = 40, ROWS = 30, SC = 1, SR = 1, EC = 38, ER = 28;

    logic        clk = 0, rst = 0;
    logic        up = 0, down = 0, left = 0, right = 0, restart = 0;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [15:0] rom_dout = 0;
    logic [5:0]  bcol, brow, ecol, erow;
    logic        win;
    logic [15:0] move_cnt;

    logic [15:0] rom [4096];
    bit          wall [64][64];

    int mrow = SR, mcol = SC, mcnt = 0;
    bit mwin = 0;
    int n_cmp = 0, n_bad = 0;

    maze_player_ctrl #(.REPEAT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .i_up(up), .i_down(down), .i_left(left), .i_right(right),
        .i_restart(restart), .o_rom_en(rom_en), .o_rom_addr(rom_addr), .i_rom_dout(rom_dout),
        .o_player_bcol(bcol), .o_player_brow(brow), .o_exit_bcol(ecol), .o_exit_brow(erow),
        .o_win(win), .o_move_cnt(move_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (rom_en) rom_dout <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cell(input int r, input int c, input bit w);
        logic [11:0] a;
        wall[r][c] = w;
        a = 12'(r * 64 + c);
        rom[a] = w ? {12'h000, 4'($urandom)} : {12'($urandom_range(1, 4095)), 4'($urandom)};
    endtask

    task automatic chk_pos(input string tag);
        chk({tag, "_row"}, brow, mrow);
        chk({tag, "_col"}, bcol, mcol);
        chk({tag, "_cnt"}, move_cnt, mcnt);
        chk({tag, "_win"}, win, mwin);
    endtask

    // One-cycle button pulse {up,down,left,right}; model resolves it on the grid.
    task automatic press(input string tag, input logic [3:0] b);
        int  dr, dc, tr, tc;
        bit  rq, inb;
        dr = 0; dc = 0;
        if (b[3]) dr = -1; else if (b[2]) dr = 1; else if (b[1]) dc = -1; else dc = 1;
        tr = mrow + dr; tc = mcol + dc;
        rq  = !mwin && (b != 0);
        inb = (tr >= 0) && (tr < ROWS) && (tc >= 0) && (tc < COLS);
        @(negedge clk); {up, down, left, right} = b;
        @(negedge clk); {up, down, left, right} = 4'b0000;
        chk({tag, "_rom_en"}, rom_en, rq && inb);
        if (rq && inb) chk({tag, "_rom_addr"}, rom_addr, tr * 64 + tc);
        @(negedge clk); chk({tag, "_rom_en_off"}, rom_en, 0);
        @(negedge clk); chk({tag, "_early"}, {brow, bcol}, {6'(mrow), 6'(mcol)});
        if (rq && inb && !wall[tr][tc]) begin
            mrow = tr; mcol = tc;
            if (mcnt != 16'hFFFF) mcnt++;
            if (tr == ER && tc == EC) mwin = 1;
        end
        @(negedge clk); chk_pos(tag);
    endtask

    task automatic do_restart(input string tag, input logic [3:0] b);
        @(negedge clk); restart = 1; {up, down, left, right} = b;
        @(negedge clk); restart = 0; {up, down, left, right} = 4'b0000;
        mrow = SR; mcol = SC; mcnt = 0; mwin = 0;
        chk_pos(tag);
        chk({tag, "_rom_en"}, rom_en, 0);
        repeat (4) @(negedge clk);
        chk_pos({tag, "_settled"});
    endtask

    initial begin
        logic [3:0] b;
        int r0;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) set_cell(r, c, $urandom_range(0, 3) == 0);
        set_cell(0, 1, 1);
        set_cell(0, 0, 0); set_cell(1, 0, 0); set_cell(1, 1, 0); set_cell(1, 2, 0);
        for (int r = 2; r < 8; r++) set_cell(r, 0, 0);

        repeat (3) @(negedge clk);
        chk_pos("reset");
        chk("reset_rom_en", rom_en, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("exit_const", {erow, ecol}, {6'(ER), 6'(EC)});
        rst = 1;
        repeat (2) @(negedge clk);

        press("right_open", 4'b0001);
        press("left_back", 4'b0010);
        press("up_wall", 4'b1000);
        press("left_10", 4'b0010);
        press("up_00", 4'b1000);
        press("left_oob", 4'b0010);
        press("up_oob", 4'b1000);
        press("down_10", 4'b0100);
        press("up_right_prio", 4'b1001);
        press("down_again", 4'b0100);

        // Hold down: edge move, then one repeat move every 16 cycles.
        r0 = mrow;
        @(negedge clk); down = 1;
        repeat (4) @(negedge clk);  chk("rep_first", brow, r0 + 1);
        repeat (15) @(negedge clk); chk("rep_wait", brow, r0 + 1);
        @(negedge clk);             chk("rep_second", brow, r0 + 2);
        repeat (15) @(negedge clk); chk("rep_wait2", brow, r0 + 2);
        @(negedge clk);             chk("rep_third", brow, r0 + 3);
        repeat (4) @(negedge clk);  down = 0;
        repeat (12) @(negedge clk);
        mrow = r0 + 3; mcnt += 3;
        chk_pos("rep_release");

        do_restart("restart_ovr", 4'b0001);

        for (int i = 0; i < 40; i++) begin
            b = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 3) != 0) b = 4'b0001 << $urandom_range(0, 3);
            press("rand", b);
        end

        do_restart("restart_pre_exit", 4'b0000);
        for (int c = SC; c <= EC; c++) set_cell(SR, c, 0);
        for (int r = SR; r <= ER; r++) set_cell(r, EC, 0);
        for (int c = SC; c < EC; c++) press("to_exit_r", 4'b0001);
        for (int r = SR; r < ER; r++) press("to_exit_d", 4'b0100);
        chk("win_reached", win, 1);
        press("win_ignore_up", 4'b1000);
        press("win_ignore_left", 4'b0010);
        do_restart("restart_win", 4'b0000);

        // Asynchronous reset while the ROM read is in flight.
        @(negedge clk); right = 1;
        @(negedge clk); right = 0;
        @(negedge clk); rst = 0;
        #1;
        mrow = SR; mcol = SC; mcnt = 0; mwin = 0;
        chk_pos("rst_mid_read");
        chk("rst_mid_rom_en", rom_en, 0);
        chk("rst_mid_rom_addr", rom_addr, 0);
        @(negedge clk); rst = 1;
        repeat (4) @(negedge clk);
        chk_pos("rst_mid_after");

        @(negedge clk);
        force dut.move_cnt = 16'hFFFE;
        #1 release dut.move_cnt;
        mcnt = 16'hFFFE;
        press("sat_to_ffff", 4'b0001);
        press("sat_hold", 4'b0010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
